sprite_rom_arbiter: RTL and testbench
=====================================

# sprite_rom_arbiter

Shares one single-port synchronous sprite/tile memory between NREQ game renderers (player, bubbles, harpoon, background line fetch) feeding the VGA path of the lab7soc system. Round-robin arbitration with bounded bursts and a display-urgent override for requester 0. Fixed read latency; returns data tagged to the originating requester.

## Interface
- NREQ, 4: number of requesters (2..8)
- AW, 12: memory word address width
- DW, 16: memory data width
- RD_LAT, 2: memory read latency in cycles (1..4), clock edges from mem_rd to mem_rdata valid
- MAX_BURST, 4: max consecutive grants to one requester while others wait (1..15)

- clk_clk  in  1  single clock, all logic on rising edge
- reset_reset_n  in  1  synchronous, active-low reset
- req  in  NREQ  per-requester read request, level
- addr  in  NREQ*AW  requester i address in bits [i*AW +: AW]
- urgent  in  1  requester 0 overrides rotation when asserted with req[0]
- gnt  out  NREQ  one-hot (or zero) grant, combinational from req/state
- rvalid  out  NREQ  one-hot, read data for requester i valid this cycle
- rdata  out  DW  registered read data, broadcast to all requesters
- mem_addr  out  AW  memory address, equals addr of granted requester
- mem_rd  out  1  read strobe, = |gnt
- mem_rdata  in  DW  memory read data, RD_LAT cycles after mem_rd

## Operation
- Each cycle at most one grant. Request accepted in the cycle gnt[i]=1; requester holds req/addr stable until granted, may change addr the cycle after.
- Selection order per cycle:
  - urgent && req[0] -> grant 0.
  - else last-granted requester L still requesting and burst_cnt < MAX_BURST-1 -> grant L again.
  - else first requesting index scanning L+1, L+2, … wrapping mod NREQ, ending at L (L itself chosen only if no other requester).
- State: last_ptr (log2 NREQ), burst_cnt (4 bits), tag pipeline of RD_LAT+1 stages, each {valid, index}.
- burst_cnt: reset to 0 when the granted index differs from last_ptr; increment when same; saturate at MAX_BURST-1. When L is sole requester it keeps being granted every cycle (no forced idle), burst_cnt stays saturated.
- Urgent grant to 0 updates last_ptr and burst_cnt like any grant.
- No grant: last_ptr and burst_cnt unchanged; tag pipeline shifts in invalid.
- Return: tag pushed at grant, shifted each cycle; mem_rdata captured into rdata when the tag reaches stage RD_LAT, rvalid[index] asserted the following cycle (registered with rdata). rdata holds last value when rvalid=0.
- Accepts one new read every cycle; no back-pressure on return path (requesters must always sink rvalid).

## Timing
- Request in cycle t with gnt -> mem_rd/mem_addr in cycle t -> rvalid/rdata in cycle t+RD_LAT+1. Total latency RD_LAT+1 clocks.
- Throughput: 1 read/cycle, back-to-back across requesters, returns in grant order.
- Reset (reset_reset_n=0 at an edge): last_ptr=NREQ-1 (so requester 0 first), burst_cnt=0, all tag valids 0, rvalid=0, rdata=0. gnt/mem_rd forced 0 while reset_reset_n=0. In-flight reads at reset are dropped, never returned.
- Simultaneous urgent with a burst in progress: urgent wins; burst owner then contends via normal rotation from last_ptr=0.
- req deasserted in same cycle as its would-be grant: no grant, no return.

## Structure
- Shared package sprite_arb_pkg: idx width function clog2, tag struct {valid, idx}, default parameter constants.
- Sub-module rr_pick: pure combinational rotating priority picker (req vector, start index -> one-hot, any); instantiated once. Top holds burst/urgent logic, state registers and tag pipeline.

## Test plan
- Reset: hold reset_reset_n=0 2 cycles with req=4'b1111 -> gnt=0, rvalid=0, rdata=0; release -> first gnt=4'b0001.
- Round robin, MAX_BURST=1: req=4'b1111 steady -> gnt sequence 0001,0010,0100,1000,0001; rvalid same sequence delayed 3 cycles (RD_LAT=2), rdata matches model memory at each addr.
- Burst: MAX_BURST=4, req=4'b0011 steady -> gnt 0001 x4, 0010 x4, 0001 x4; req=4'b0100 only -> 0100 every cycle indefinitely.
- Urgent: requester 2 mid-burst (cnt=2), assert urgent with req[0] -> next gnt=0001; release urgent -> next gnt=0010 if req[1], else 0100.
- Reset mid-flight: grant reads in cycles t, t+1, reset at t+2 -> no rvalid in t+3..t+5; post-reset reads return correctly.
- Random: random req/addr/urgent 10k cycles -> gnt one-hot or zero, every grant returns exactly one rvalid after RD_LAT+1 with correct data, no requester starved beyond (NREQ-1)*MAX_BURST cycles while urgent=0.

Source files
------------

// File: rtl/sprite_arb_pkg.sv
// Shared types, defaults and helpers for the sprite ROM arbiter.
package sprite_arb_pkg;

  localparam int unsigned DEF_NREQ      = 4;
  localparam int unsigned DEF_AW        = 12;
  localparam int unsigned DEF_DW        = 16;
  localparam int unsigned DEF_RD_LAT    = 2;
  localparam int unsigned DEF_MAX_BURST = 4;

  // Requester index field in a tag; wide enough for up to 8 requesters.
  localparam int unsigned TAG_IDX_W = 3;

  // Ceiling log2; clog2(1) = 0.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int unsigned v = n - 32'd1; v > 0; v = v >> 1) begin
      r = r + 32'd1;
    end
    return r;
  endfunction

  // Index width for n requesters, never below one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n < 32'd2) ? 32'd1 : clog2(n);
  endfunction

  // In-flight read tag travelling alongside the memory latency.
  typedef struct packed {
    logic                 valid;
    logic [TAG_IDX_W-1:0] idx;
  } tag_t;

  // Which arbitration rule produced this cycle's grant.
  typedef enum logic [1:0] {
    SRC_NONE   = 2'd0,
    SRC_URGENT = 2'd1,
    SRC_BURST  = 2'd2,
    SRC_ROTATE = 2'd3
  } gnt_src_e;

endpackage

// File: rtl/sprite_rom_arbiter_rr_pick.sv
// Rotating priority picker: first set request scanning from i_start upward, wrapping.
module rr_pick
  import sprite_arb_pkg::*;
#(
  parameter int unsigned NREQ = DEF_NREQ,
  parameter int unsigned IW   = idx_width(DEF_NREQ)
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [IW-1:0]   i_start,
  output logic [NREQ-1:0] o_gnt,
  output logic [IW-1:0]   o_idx,
  output logic            o_any
);

  int unsigned w_pos;

  // Scan NREQ positions starting at i_start; the first hit wins.
  always_comb begin
    o_gnt = '0;
    o_idx = '0;
    o_any = 1'b0;
    w_pos = '0;
    for (int unsigned off = 0; off < NREQ; off++) begin
      w_pos = 32'(i_start) + off;
      if (w_pos >= NREQ) begin
        w_pos = w_pos - NREQ;
      end
      if (!o_any && i_req[IW'(w_pos)]) begin
        o_any = 1'b1;
        o_idx = IW'(w_pos);
      end
    end
    if (o_any) begin
      o_gnt[o_idx] = 1'b1;
    end
  end

endmodule

// File: rtl/sprite_rom_arbiter.sv
// Shares one single-port synchronous sprite memory between NREQ renderers:
// round robin with bounded bursts, urgent override for requester 0,
// fixed-latency return tagged to the originating requester.
module sprite_rom_arbiter
  import sprite_arb_pkg::*;
#(
  parameter int unsigned NREQ      = DEF_NREQ,
  parameter int unsigned AW        = DEF_AW,
  parameter int unsigned DW        = DEF_DW,
  parameter int unsigned RD_LAT    = DEF_RD_LAT,
  parameter int unsigned MAX_BURST = DEF_MAX_BURST
) (
  input  logic                 clk_clk,
  input  logic                 reset_reset_n,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*AW-1:0]   addr,
  input  logic                 urgent,
  output logic [NREQ-1:0]      gnt,
  output logic [NREQ-1:0]      rvalid,
  output logic [DW-1:0]        rdata,
  output logic [AW-1:0]        mem_addr,
  output logic                 mem_rd,
  input  logic [DW-1:0]        mem_rdata
);

  localparam int unsigned    IW        = idx_width(NREQ);
  localparam logic [IW-1:0]  LAST_IDX  = IW'(NREQ - 1);
  localparam logic [3:0]     BURST_LIM = 4'(MAX_BURST - 1);

  // Arbitration state. r_owned is clear until the first grant after reset, so
  // the reset value of r_last_ptr only seeds rotation and never starts a burst.
  logic [IW-1:0]   r_last_ptr;
  logic [3:0]      r_burst_cnt;
  logic            r_owned;

  // Return path state.
  tag_t            r_tag [RD_LAT];
  logic [NREQ-1:0] r_rvalid;
  logic [DW-1:0]   r_rdata;

  logic [IW-1:0]   w_start;
  logic [NREQ-1:0] w_rr_gnt;
  logic [IW-1:0]   w_rr_idx;
  logic            w_rr_any;
  gnt_src_e        w_src;
  logic [NREQ-1:0] w_gnt;
  logic [IW-1:0]   w_gnt_idx;
  logic            w_gnt_vld;
  logic [AW-1:0]   w_mem_addr;
  tag_t            w_tag_in;
  tag_t            w_ret;
  logic [NREQ-1:0] w_ret_onehot;

  // Rotation starts one past the last granted requester.
  always_comb begin
    w_start = (r_last_ptr == LAST_IDX) ? '0 : r_last_ptr + IW'(1);
  end

  rr_pick #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_rr_pick (
    .i_req   (req),
    .i_start (w_start),
    .o_gnt   (w_rr_gnt),
    .o_idx   (w_rr_idx),
    .o_any   (w_rr_any)
  );

  // Grant selection: urgent, then burst continuation, then rotation; none in reset.
  always_comb begin
    w_src     = SRC_NONE;
    w_gnt     = '0;
    w_gnt_idx = r_last_ptr;
    if (!reset_reset_n) begin
      w_src = SRC_NONE;
    end else if (urgent && req[0]) begin
      w_src = SRC_URGENT;
    end else if (r_owned && req[r_last_ptr] && (r_burst_cnt < BURST_LIM)) begin
      w_src = SRC_BURST;
    end else if (w_rr_any) begin
      w_src = SRC_ROTATE;
    end

    case (w_src)
      SRC_URGENT: begin
        w_gnt_idx = '0;
        w_gnt[0]  = 1'b1;
      end
      SRC_BURST: begin
        w_gnt_idx           = r_last_ptr;
        w_gnt[r_last_ptr]   = 1'b1;
      end
      SRC_ROTATE: begin
        w_gnt_idx = w_rr_idx;
        w_gnt     = w_rr_gnt;
      end
      default: begin
        w_gnt_idx = r_last_ptr;
        w_gnt     = '0;
      end
    endcase
  end

  assign w_gnt_vld = (w_src != SRC_NONE);

  // Address mux for the granted requester; parked at zero when idle.
  always_comb begin
    w_mem_addr = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (w_gnt[i]) begin
        w_mem_addr = addr[i*AW +: AW];
      end
    end
  end

  // Last pointer and burst counter follow every grant, urgent ones included.
  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      r_last_ptr  <= LAST_IDX;
      r_burst_cnt <= '0;
      r_owned     <= 1'b0;
    end else if (w_gnt_vld) begin
      r_last_ptr <= w_gnt_idx;
      r_owned    <= 1'b1;
      if (!r_owned || (w_gnt_idx != r_last_ptr)) begin
        r_burst_cnt <= '0;
      end else if (r_burst_cnt < BURST_LIM) begin
        r_burst_cnt <= r_burst_cnt + 4'd1;
      end
    end
  end

  always_comb begin
    w_tag_in       = '0;
    w_tag_in.valid = w_gnt_vld;
    w_tag_in.idx   = TAG_IDX_W'(w_gnt_idx);
  end

  // Tag shift register matching the memory latency; reset drops in-flight reads.
  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      for (int unsigned k = 0; k < RD_LAT; k++) begin
        r_tag[k] <= '0;
      end
    end else begin
      r_tag[0] <= w_tag_in;
      for (int unsigned k = 1; k < RD_LAT; k++) begin
        r_tag[k] <= r_tag[k-1];
      end
    end
  end

  assign w_ret = r_tag[RD_LAT-1];

  // Decode the returning tag to a one-hot valid.
  always_comb begin
    w_ret_onehot = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      w_ret_onehot[i] = w_ret.valid && (w_ret.idx == TAG_IDX_W'(i));
    end
  end

  // Capture memory data when its tag arrives; rdata holds between returns.
  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      r_rvalid <= '0;
      r_rdata  <= '0;
    end else begin
      r_rvalid <= w_ret_onehot;
      if (w_ret.valid) begin
        r_rdata <= mem_rdata;
      end
    end
  end

  assign gnt      = w_gnt;
  assign mem_rd   = w_gnt_vld;
  assign mem_addr = w_mem_addr;
  assign rvalid   = r_rvalid;
  assign rdata    = r_rdata;

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// Bench for sprite_rom_arbiter: directed literal sequences plus randomized traffic
// against a grant-counting reference model and a return scoreboard.
module tb_sprite_rom_arbiter;

  localparam int NREQ      = 4;
  localparam int AW        = 12;
  localparam int DW        = 16;
  localparam int RD_LAT    = 2;
  localparam int MAX_BURST = 4;
  localparam int STARVE    = (NREQ - 1) * MAX_BURST;

  logic                clk;
  logic                rst_n;
  logic [NREQ-1:0]     req;
  logic [AW-1:0]       a_addr [NREQ];
  logic [NREQ*AW-1:0]  addr;
  logic                urgent;
  logic [NREQ-1:0]     gnt;
  logic [NREQ-1:0]     rvalid;
  logic [DW-1:0]       rdata;
  logic [AW-1:0]       mem_addr;
  logic                mem_rd;
  logic [DW-1:0]       mem_rdata;

  logic [DW-1:0]       mem [1 << AW];
  logic [DW-1:0]       mpipe [RD_LAT];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  sprite_rom_arbiter #(
    .NREQ      (NREQ),
    .AW        (AW),
    .DW        (DW),
    .RD_LAT    (RD_LAT),
    .MAX_BURST (MAX_BURST)
  ) dut (
    .clk_clk       (clk),
    .reset_reset_n (rst_n),
    .req           (req),
    .addr          (addr),
    .urgent        (urgent),
    .gnt           (gnt),
    .rvalid        (rvalid),
    .rdata         (rdata),
    .mem_addr      (mem_addr),
    .mem_rd        (mem_rd),
    .mem_rdata     (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < NREQ; i++) addr[i*AW +: AW] = a_addr[i];
  end

  // Synchronous memory with RD_LAT register stages; junk when not reading.
  always @(posedge clk) begin
    mpipe[0] <= mem_rd ? mem[mem_addr] : DW'($urandom);
    for (int k = 1; k < RD_LAT; k++) mpipe[k] <= mpipe[k-1];
  end
  assign mem_rdata = mpipe[RD_LAT-1];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  // m_run counts consecutive grants to m_last; 0 means nobody granted since reset.
  int m_last = NREQ - 1;
  int m_run  = 0;
  logic [DW-1:0] last_rd = '0;
  int wt [NREQ];

  typedef struct {
    int            due;
    int            idx;
    logic [DW-1:0] data;
  } ret_t;
  ret_t q[$];

  function automatic int model_pick(input logic [NREQ-1:0] r, input logic u);
    if (u && r[0]) return 0;
    if (m_run > 0 && m_run < MAX_BURST && r[m_last]) return m_last;
    for (int k = 1; k <= NREQ; k++) begin
      int j;
      j = (m_last + k) % NREQ;
      if (r[j]) return j;
    end
    return -1;
  endfunction

  initial for (int i = 0; i < NREQ; i++) wt[i] = 0;

  // Per-cycle compare against the model, then advance the model over the coming edge.
  always @(negedge clk) begin : cmp
    int g;
    logic [NREQ-1:0] eg;
    g  = rst_n ? model_pick(req, urgent) : -1;
    eg = (g >= 0) ? (NREQ'(1) << g) : '0;
    chk("gnt", 32'(gnt), 32'(eg));
    chk("mem_rd", 32'(mem_rd), 32'(|eg));
    if (g >= 0) chk("mem_addr", 32'(mem_addr), 32'(a_addr[g]));

    if (q.size() > 0 && q[0].due == cyc) begin
      chk("rvalid", 32'(rvalid), 32'(NREQ'(1) << q[0].idx));
      chk("rdata", 32'(rdata), 32'(q[0].data));
      last_rd = q[0].data;
      void'(q.pop_front());
    end else begin
      chk("rvalid_idle", 32'(rvalid), 32'(0));
      chk("rdata_hold", 32'(rdata), 32'(last_rd));
    end

    for (int i = 0; i < NREQ; i++) begin
      if (!rst_n || urgent || !req[i] || eg[i]) begin
        wt[i] = 0;
      end else begin
        wt[i]++;
        n_checks++;
        if (wt[i] > STARVE) begin
          n_fail++;
          $display("FAIL starve: req%0d waited %0d cycles, limit %0d (cycle %0d)", i, wt[i], STARVE, cyc);
        end
      end
    end

    if (!rst_n) begin
      q.delete();
      last_rd = '0;
      m_last  = NREQ - 1;
      m_run   = 0;
    end else if (g >= 0) begin
      q.push_back('{due: cyc + RD_LAT + 1, idx: g, data: mem[a_addr[g]]});
      if (g == m_last && m_run > 0) m_run = (m_run < MAX_BURST) ? m_run + 1 : MAX_BURST;
      else m_run = 1;
      m_last = g;
    end
    cyc++;
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Check the combinational grant for the current cycle, then move to the next one.
  task automatic cyc_gnt(input string nm, input logic [NREQ-1:0] e);
    #1;
    chk(nm, 32'(gnt), 32'(e));
    step();
  endtask

  initial begin
    logic [NREQ-1:0] seq_rr [8];
    logic [NREQ-1:0] seq_b  [12];
    logic [NREQ-1:0] pg;
    seq_rr = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0010, 4'b0010, 4'b0010, 4'b0010};
    seq_b  = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0010, 4'b0010, 4'b0010, 4'b0010,
               4'b0001, 4'b0001, 4'b0001, 4'b0001};

    for (int a = 0; a < (1 << AW); a++) mem[a] = DW'($urandom);
    for (int i = 0; i < NREQ; i++) a_addr[i] = AW'($urandom);
    rst_n  = 1'b0;
    req    = 4'b1111;
    urgent = 1'b0;

    // Reset with everyone requesting.
    step();
    #1;
    chk("rst_rvalid", 32'(rvalid), 32'(0));
    chk("rst_rdata", 32'(rdata), 32'(0));
    cyc_gnt("rst_gnt", 4'b0000);
    cyc_gnt("rst_gnt", 4'b0000);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) cyc_gnt("all_req", seq_rr[i]);

    // Two requesters alternate in bursts of MAX_BURST.
    rst_n = 1'b0;
    cyc_gnt("p2_rst", 4'b0000);
    rst_n = 1'b1;
    req   = 4'b0011;
    for (int i = 0; i < 12; i++) cyc_gnt("burst", seq_b[i]);

    // Sole requester is granted every cycle.
    req = 4'b0100;
    for (int i = 0; i < 10; i++) cyc_gnt("sole", 4'b0100);

    // Urgent preempts requester 2 mid-burst; rotation resumes from 0.
    rst_n = 1'b0;
    cyc_gnt("p4_rst", 4'b0000);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) cyc_gnt("pre_urg", 4'b0100);
    req    = 4'b0111;
    urgent = 1'b1;
    cyc_gnt("urgent", 4'b0001);
    urgent = 1'b0;
    req    = 4'b0110;
    cyc_gnt("post_urg", 4'b0010);
    req = 4'b0100;
    cyc_gnt("post_urg2", 4'b0100);
    req = 4'b0000;
    for (int i = 0; i < 4; i++) cyc_gnt("idle", 4'b0000);

    // Reset while two reads are in flight: neither may return.
    req = 4'b0001;
    cyc_gnt("mf_a", 4'b0001);
    cyc_gnt("mf_b", 4'b0001);
    req   = 4'b0000;
    rst_n = 1'b0;
    cyc_gnt("mf_rst", 4'b0000);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("mf_drop", 32'(rvalid), 32'(0));
      step();
    end
    req       = 4'b0010;
    a_addr[1] = 12'h5A5;
    cyc_gnt("mf_post", 4'b0010);
    req = 4'b0000;
    step();
    step();
    #1;
    chk("mf_ret_v", 32'(rvalid), 32'(4'b0010));
    chk("mf_ret_d", 32'(rdata), 32'(mem[12'h5A5]));
    step();

    // Randomized traffic; requests hold until granted, with rare early drops.
    pg = '0;
    for (int n = 0; n < 10000; n++) begin
      rst_n  = ($urandom_range(0, 1499) != 0);
      urgent = urgent ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 31) == 0);
      for (int i = 0; i < NREQ; i++) begin
        if (req[i] && pg[i]) begin
          req[i]    = 1'($urandom_range(0, 1));
          a_addr[i] = AW'($urandom);
        end else if (req[i]) begin
          if ($urandom_range(0, 63) == 0) req[i] = 1'b0;
        end else if ($urandom_range(0, 2) == 0) begin
          req[i]    = 1'b1;
          a_addr[i] = AW'($urandom);
        end
      end
      #2;
      pg = gnt;
      step();
    end

    rst_n  = 1'b1;
    urgent = 1'b0;
    req    = '0;
    repeat (8) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
